// File: rtl/resp_misr_capture.sv
// Response capture block: a small FIFO buffering decoder response words,
// with a MISR signature, a saturating accepted-word counter and sticky
// structural checks on the 39-bit response vector (bit 0 = g25 ... bit 38 = g63).
// DEPTH must be a power of two and at least 2.
module resp_misr_capture #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [38:0]      in_data,
  output logic             in_ready,
  input  logic             sig_clear,
  output logic             out_valid,
  output logic [38:0]      out_data,
  input  logic             out_ready,
  output logic [38:0]      sig,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             err_const,
  output logic             err_dup,
  output logic [CNT_W-1:0] err_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Feedback taps of x^39 + x^4 + 1 once the top bit has been shifted out.
  localparam logic [38:0] POLY = 39'h11;

  // Response bits that a healthy decoder always drives low.
  localparam logic [38:0] CONST_MASK =
      (39'd1 << 19) | (39'd1 << 20) | (39'd1 << 23) | (39'd1 << 24) |
      (39'd1 << 27) | (39'd1 << 28) | (39'd1 << 31) | (39'd1 << 32) |
      (39'd1 << 35) | (39'd1 << 36);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [38:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // No bypass: a full FIFO refuses a push even when the head is popped.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Write the accepted word into the slot at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the storage array is reset as well, so the head word (and hence
    // out_data) reads zero while rst is high instead of stale or X data.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Advance the pointers on push/pop; power-of-two depth wraps them for free.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking ones would make results depend on block order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Track occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response checks on the incoming word
  // ---------------------------------------------------------------------------
  logic [4:0] dup_grp;
  logic       const_hit;
  logic       dup_hit;

  assign dup_grp   = {in_data[37], in_data[33], in_data[29], in_data[25], in_data[21]};
  assign const_hit = |(in_data & CONST_MASK);
  assign dup_hit   = ((|dup_grp) & ~(&dup_grp)) | (in_data[9] ^ in_data[13]);

  // ---------------------------------------------------------------------------
  // Signature, counter and error state
  // ---------------------------------------------------------------------------
  logic [38:0]      sig_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] idx_next;
  logic             const_next;
  logic             dup_next;

  // Next-state for the capture registers; sig_clear wins over a same-cycle
  // accept, whose word still goes into the FIFO untouched.
  always_comb begin
    // NOTE: every output gets a hold default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    sig_next   = sig;
    cnt_next   = vec_cnt;
    idx_next   = err_idx;
    const_next = err_const;
    dup_next   = err_dup;
    if (sig_clear) begin
      sig_next   = '0;
      cnt_next   = '0;
      idx_next   = '0;
      const_next = 1'b0;
      dup_next   = 1'b0;
    end else if (push) begin
      sig_next = {sig[37:0], 1'b0} ^ (sig[38] ? POLY : '0) ^ in_data;
      if (vec_cnt != '1) begin
        cnt_next = vec_cnt + CNT_W'(1);
      end
      // Only the first failing word since the last clear is recorded.
      if ((const_hit | dup_hit) & ~err_const & ~err_dup) begin
        idx_next = vec_cnt;
      end
      const_next = err_const | const_hit;
      dup_next   = err_dup | dup_hit;
    end
  end

  // Register the capture state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig       <= '0;
      vec_cnt   <= '0;
      err_idx   <= '0;
      err_const <= 1'b0;
      err_dup   <= 1'b0;
    end else begin
      sig       <= sig_next;
      vec_cnt   <= cnt_next;
      err_idx   <= idx_next;
      err_const <= const_next;
      err_dup   <= dup_next;
    end
  end

endmodule
